eh2_dec_trigger_csr: RTL and testbench

//  Per-thread trigger CSR file (tselect/tdata1/tdata2) in the TLU; upstream of the decode trigger matcher.

---
 rtl/eh2_dec_trigger_csr.sv | 189 ++++++++++++++++++
 tb/tb_eh2_dec_trigger_csr.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eh2_dec_trigger_csr.sv
// eh2_dec_trigger_csr
//   Per-thread debug trigger CSR file (tselect / tdata1 / tdata2) for the TLU.
//   Holds four mcontrol-type triggers per thread and presents their stored
//   match controls to the decode trigger matcher every cycle.
//
// Ports
//   clk_i, rst_l_i            core clock, synchronous active-low reset
//   dec_csr_wen_i/wtid/waddr/wdata  CSR write port (0x7A0 tselect, 0x7A1 tdata1,
//                             0x7A2 tdata2); writes commit at the next edge
//   dec_csr_ren_i/rtid/raddr  CSR read port; data registered at the ren edge
//   dbg_mode_i                per-thread debug-mode flag
//   trigger_hit_i             per thread/trigger hit pulse, index t*4+i
//   trig_csr_rdata_o/rvalid_o registered read data and one-cycle valid
//   trigger_pkt_*_o           flattened trigger packet, entry t*4+i
//                             (tdata2 entry e lives at bits [e*32 +: 32])
//
// Configuration
//   RV_TRIGGER_CHAIN_EN  when defined, triggers 0 and 2 have a writable chain
//                        bit; otherwise chain is hardwired 0.
module eh2_dec_trigger_csr #(
    parameter int unsigned NUM_THREADS = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_l_i,
    input  logic                          dec_csr_wen_i,
    input  logic                          dec_csr_wtid_i,
    input  logic [11:0]                   dec_csr_waddr_i,
    input  logic [31:0]                   dec_csr_wdata_i,
    input  logic                          dec_csr_ren_i,
    input  logic                          dec_csr_rtid_i,
    input  logic [11:0]                   dec_csr_raddr_i,
    input  logic [NUM_THREADS-1:0]        dbg_mode_i,
    input  logic [NUM_THREADS*4-1:0]      trigger_hit_i,
    output logic [31:0]                   trig_csr_rdata_o,
    output logic                          trig_csr_rvalid_o,
    output logic [NUM_THREADS*4-1:0]      trigger_pkt_select_o,
    output logic [NUM_THREADS*4-1:0]      trigger_pkt_match_o,
    output logic [NUM_THREADS*4-1:0]      trigger_pkt_store_o,
    output logic [NUM_THREADS*4-1:0]      trigger_pkt_load_o,
    output logic [NUM_THREADS*4-1:0]      trigger_pkt_execute_o,
    output logic [NUM_THREADS*4-1:0]      trigger_pkt_m_o,
    output logic [NUM_THREADS*4*32-1:0]   trigger_pkt_tdata2_o
);

    localparam int unsigned NumTrig = 4;
    localparam int unsigned NumEnt  = NUM_THREADS * NumTrig;
    localparam int unsigned IdxW    = $clog2(NumEnt);

    localparam logic [11:0] AddrTselect = 12'h7A0;
    localparam logic [11:0] AddrTdata1  = 12'h7A1;
    localparam logic [11:0] AddrTdata2  = 12'h7A2;

    logic [NUM_THREADS-1:0][1:0] tselect_q, tselect_d;
    logic [NumEnt-1:0] dmode_q, dmode_d, hit_q, hit_d, select_q, select_d;
    logic [NumEnt-1:0] action_q, action_d, chain_q, chain_d, match_q, match_d;
    logic [NumEnt-1:0] m_q, m_d, execute_q, execute_d, store_q, store_d;
    logic [NumEnt-1:0] load_q, load_d;
    logic [NumEnt-1:0][31:0] tdata2_q, tdata2_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic [IdxW-1:0] widx, ridx, nidx;
    logic            wr_dbg, wr_lock, wr_tsel, wr_t1, wr_t2, chain_blk;
    logic [31:0]     t1_rd, rd_val;

    // Write-side decode: tdata accesses target the thread's selected trigger.
    always_comb begin
        widx      = IdxW'({dec_csr_wtid_i, tselect_q[dec_csr_wtid_i]});
        nidx      = widx | IdxW'(1);  // partner trigger of an even-numbered one
        wr_dbg    = dbg_mode_i[dec_csr_wtid_i];
        wr_lock   = dmode_q[widx] & ~wr_dbg;
        chain_blk = dmode_q[nidx] & ~wr_dbg;
        wr_tsel   = dec_csr_wen_i & (dec_csr_waddr_i == AddrTselect) &
                    (dec_csr_wdata_i[31:2] == 30'd0);
        wr_t1     = dec_csr_wen_i & (dec_csr_waddr_i == AddrTdata1) & ~wr_lock;
        wr_t2     = dec_csr_wen_i & (dec_csr_waddr_i == AddrTdata2) & ~wr_lock;
    end

    always_comb begin
        tselect_d = tselect_q;
        dmode_d   = dmode_q;
        select_d  = select_q;
        action_d  = action_q;
        chain_d   = chain_q;
        match_d   = match_q;
        m_d       = m_q;
        execute_d = execute_q;
        store_d   = store_q;
        load_d    = load_q;
        tdata2_d  = tdata2_q;
        hit_d     = hit_q | trigger_hit_i;

        if (wr_tsel) begin
            tselect_d[dec_csr_wtid_i] = dec_csr_wdata_i[1:0];
        end

        for (int unsigned e = 0; e < NumEnt; e++) begin
            if (wr_t1 && (widx == IdxW'(e))) begin
                dmode_d[e]   = dec_csr_wdata_i[27] & wr_dbg;
                // A same-cycle hit pulse must not be lost to a software write.
                hit_d[e]     = dec_csr_wdata_i[20] | trigger_hit_i[e];
                select_d[e]  = dec_csr_wdata_i[19];
                action_d[e]  = (dec_csr_wdata_i[15:12] == 4'd1);
`ifdef RV_TRIGGER_CHAIN_EN
                chain_d[e]   = ((e % 2) == 0) & dec_csr_wdata_i[11] & ~chain_blk;
`else
                chain_d[e]   = 1'b0;
`endif
                match_d[e]   = dec_csr_wdata_i[7];
                m_d[e]       = dec_csr_wdata_i[6];
                execute_d[e] = dec_csr_wdata_i[2];
                store_d[e]   = dec_csr_wdata_i[1];
                load_d[e]    = dec_csr_wdata_i[0];
            end
            if (wr_t2 && (widx == IdxW'(e))) begin
                tdata2_d[e] = dec_csr_wdata_i;
            end
        end
    end

    // Read mux samples pre-write state, so a same-cycle write is not visible.
    always_comb begin
        ridx  = IdxW'({dec_csr_rtid_i, tselect_q[dec_csr_rtid_i]});
        t1_rd = {4'h2, dmode_q[ridx], 6'd31, hit_q[ridx], select_q[ridx], 1'b0,
                 2'b00, 3'b000, action_q[ridx], chain_q[ridx], 3'b000, match_q[ridx],
                 m_q[ridx], 3'b000, execute_q[ridx], store_q[ridx], load_q[ridx]};
        unique case (dec_csr_raddr_i)
            AddrTselect: rd_val = {30'd0, tselect_q[dec_csr_rtid_i]};
            AddrTdata1:  rd_val = t1_rd;
            AddrTdata2:  rd_val = tdata2_q[ridx];
            default:     rd_val = 32'd0;
        endcase
        rvalid_d = dec_csr_ren_i;
        rdata_d  = dec_csr_ren_i ? rd_val : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_l_i) begin
            tselect_q <= '0;
            dmode_q   <= '0;
            hit_q     <= '0;
            select_q  <= '0;
            action_q  <= '0;
            chain_q   <= '0;
            match_q   <= '0;
            m_q       <= '0;
            execute_q <= '0;
            store_q   <= '0;
            load_q    <= '0;
            tdata2_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            tselect_q <= tselect_d;
            dmode_q   <= dmode_d;
            hit_q     <= hit_d;
            select_q  <= select_d;
            action_q  <= action_d;
            chain_q   <= chain_d;
            match_q   <= match_d;
            m_q       <= m_d;
            execute_q <= execute_d;
            store_q   <= store_d;
            load_q    <= load_d;
            tdata2_q  <= tdata2_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Machine-mode match is suppressed in debug mode so nothing fires there.
    always_comb begin
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            for (int unsigned i = 0; i < NumTrig; i++) begin
                trigger_pkt_m_o[t*NumTrig+i] = m_q[t*NumTrig+i] & ~dbg_mode_i[t];
            end
        end
    end

    assign trig_csr_rdata_o      = rdata_q;
    assign trig_csr_rvalid_o     = rvalid_q;
    assign trigger_pkt_select_o  = select_q;
    assign trigger_pkt_match_o   = match_q;
    assign trigger_pkt_store_o   = store_q;
    assign trigger_pkt_load_o    = load_q;
    assign trigger_pkt_execute_o = execute_q;
    assign trigger_pkt_tdata2_o  = tdata2_q;

endmodule

// File: tb/tb_eh2_dec_trigger_csr.sv
module tb_eh2_dec_trigger_csr;

`ifdef RV_TRIGGER_CHAIN_EN
    localparam bit ChainEn = 1'b1;
`else
    localparam bit ChainEn = 1'b0;
`endif
    // tdata1 read-only fields: type=2 at [31:28], maskmax=31 at [26:21].
    localparam logic [31:0] T1Base = 32'h23E0_0000;
    // Plain stored bits: hit, select, match[7], m, execute, store, load.
    localparam logic [31:0] T1Plain = 32'h0018_00C7;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        wen, wtid, ren, rtid;
    logic [11:0] waddr, raddr;
    logic [31:0] wdata;
    logic [1:0]  dbg;
    logic [7:0]  hit;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  p_sel, p_match, p_store, p_load, p_exe, p_m;
    logic [255:0] p_tdata2;

    always #5 clk = ~clk;

    eh2_dec_trigger_csr #(.NUM_THREADS(2)) dut (
        .clk_i                 (clk),
        .rst_l_i               (rst_l),
        .dec_csr_wen_i         (wen),
        .dec_csr_wtid_i        (wtid),
        .dec_csr_waddr_i       (waddr),
        .dec_csr_wdata_i       (wdata),
        .dec_csr_ren_i         (ren),
        .dec_csr_rtid_i        (rtid),
        .dec_csr_raddr_i       (raddr),
        .dbg_mode_i            (dbg),
        .trigger_hit_i         (hit),
        .trig_csr_rdata_o      (rdata),
        .trig_csr_rvalid_o     (rvalid),
        .trigger_pkt_select_o  (p_sel),
        .trigger_pkt_match_o   (p_match),
        .trigger_pkt_store_o   (p_store),
        .trigger_pkt_load_o    (p_load),
        .trigger_pkt_execute_o (p_exe),
        .trigger_pkt_m_o       (p_m),
        .trigger_pkt_tdata2_o  (p_tdata2)
    );

    // Reference model: architectural register contents as software sees them.
    logic [31:0] m_t1 [2][4];
    logic [31:0] m_t2 [2][4];
    int unsigned m_tsel [2];
    logic [31:0] m_last;

    typedef struct {
        int unsigned tag;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t rdq[$];

    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          started  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp,
                     edge_cnt);
        end
    endtask

    function automatic logic [31:0] model_read(input int t, input logic [11:0] a);
        case (a)
            12'h7A0: return 32'(m_tsel[t]);
            12'h7A1: return m_t1[t][m_tsel[t]];
            12'h7A2: return m_t2[t][m_tsel[t]];
            default: return 32'd0;
        endcase
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        int          t, idx;
        bit          locked;
        logic [31:0] nw;
        edge_cnt++;
        if (!rst_l) begin
            for (int a = 0; a < 2; a++) begin
                m_tsel[a] = 0;
                for (int b = 0; b < 4; b++) begin
                    m_t1[a][b] = T1Base;
                    m_t2[a][b] = 32'd0;
                end
            end
            m_last = 32'd0;
            rdq.delete();
            return;
        end
        if (ren) begin
            m_last = model_read(int'(rtid), raddr);
            rdq.push_back('{tag: edge_cnt, data: m_last});
        end
        if (wen) begin
            t      = int'(wtid);
            idx    = int'(m_tsel[t]);
            locked = m_t1[t][idx][27] && !dbg[t];
            if (waddr == 12'h7A0) begin
                if ((wdata >> 2) == 0) m_tsel[t] = int'(wdata);
            end else if (waddr == 12'h7A1 && !locked) begin
                nw = T1Base | (wdata & T1Plain);
                if (wdata[27] && dbg[t]) nw = nw | (32'd1 << 27);
                if (((wdata >> 12) & 32'hF) == 32'd1) nw = nw | (32'd1 << 12);
                if (ChainEn && (idx % 2 == 0) && wdata[11] &&
                    !(m_t1[t][idx+1][27] && !dbg[t]))
                    nw = nw | (32'd1 << 11);
                m_t1[t][idx] = nw;
            end else if (waddr == 12'h7A2 && !locked) begin
                m_t2[t][idx] = wdata;
            end
        end
        for (int e = 0; e < 8; e++) begin
            if (hit[e]) m_t1[e/4][e%4] = m_t1[e/4][e%4] | (32'd1 << 20);
        end
    endtask

    // Monitor: compares read responses and the packet between clock edges.
    always @(negedge clk) begin
        logic [7:0] es, em, est, el, ex, emm;
        rd_exp_t    x;
        if (started) begin
            if (rdq.size() != 0 && rdq[0].tag == edge_cnt) begin
                x = rdq.pop_front();
                chk("rvalid", 32'(rvalid), 32'd1);
                chk("rdata", rdata, x.data);
            end else begin
                chk("rvalid_idle", 32'(rvalid), 32'd0);
            end
            chk("rdata_hold", rdata, m_last);
            for (int e = 0; e < 8; e++) begin
                es[e]  = m_t1[e/4][e%4][19];
                em[e]  = m_t1[e/4][e%4][7];
                est[e] = m_t1[e/4][e%4][1];
                el[e]  = m_t1[e/4][e%4][0];
                ex[e]  = m_t1[e/4][e%4][2];
                emm[e] = m_t1[e/4][e%4][6] & ~dbg[e/4];
                chk($sformatf("pkt_tdata2[%0d]", e), p_tdata2[e*32 +: 32], m_t2[e/4][e%4]);
            end
            chk("pkt_select", 32'(p_sel), 32'(es));
            chk("pkt_match", 32'(p_match), 32'(em));
            chk("pkt_store", 32'(p_store), 32'(est));
            chk("pkt_load", 32'(p_load), 32'(el));
            chk("pkt_execute", 32'(p_exe), 32'(ex));
            chk("pkt_m", 32'(p_m), 32'(emm));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        wen = 1'b0;
        ren = 1'b0;
        hit = 8'd0;
        rst_l = 1'b1;
    endtask

    task automatic wr(input logic t, input logic [11:0] a, input logic [31:0] d);
        wen = 1'b1; wtid = t; waddr = a; wdata = d;
        tick();
    endtask

    task automatic rd(input logic t, input logic [11:0] a);
        ren = 1'b1; rtid = t; raddr = a;
        tick();
    endtask

    initial begin
        logic [11:0] addrs [8];
        addrs = '{12'h7A0, 12'h7A1, 12'h7A1, 12'h7A1, 12'h7A2, 12'h7A2, 12'h7A3, 12'h000};
        rst_l = 1'b0; wen = 1'b0; ren = 1'b0; wtid = 1'b0; rtid = 1'b0;
        waddr = 12'd0; raddr = 12'd0; wdata = 32'd0; dbg = 2'b00; hit = 8'd0;

        // Reset held for two edges, then read trigger 0 tdata1.
        @(posedge clk); model_edge(); #2;
        started = 1'b1;
        rst_l = 1'b0;
        tick();
        rd(1'b0, 12'h7A1);
        tick();

        // PC trigger on thread 0, trigger 1.
        wr(1'b0, 12'h7A0, 32'd1);
        wr(1'b0, 12'h7A2, 32'h8000_0100);
        wr(1'b0, 12'h7A1, 32'h2F80_0044);
        rd(1'b0, 12'h7A1);
        dbg = 2'b01;      // m must drop while in debug mode
        tick();
        dbg = 2'b00;

        // dmode lock on trigger 2.
        dbg = 2'b01;
        wr(1'b0, 12'h7A0, 32'd2);
        wr(1'b0, 12'h7A1, 32'h2F80_0044 | (32'd1 << 27));
        dbg = 2'b00;
        wr(1'b0, 12'h7A2, 32'h0000_1234);
        wr(1'b0, 12'h7A1, 32'h0000_0000);
        rd(1'b0, 12'h7A2);
        rd(1'b0, 12'h7A1);

        // Hit pulse racing a tdata1 write on trigger 3, plus a lone hit.
        wr(1'b0, 12'h7A0, 32'd3);
        hit = 8'b0000_1000;
        wr(1'b0, 12'h7A1, 32'h2F80_0004);
        rd(1'b0, 12'h7A1);
        hit = 8'b0100_0000;
        tick();
        wr(1'b0, 12'h7A1, 32'h0000_0004);
        rd(1'b0, 12'h7A1);

        // Chain on trigger 0 with trigger 1 locked, then unlocked.
        dbg = 2'b01;
        wr(1'b0, 12'h7A0, 32'd1);
        wr(1'b0, 12'h7A1, 32'h0800_0000);
        dbg = 2'b00;
        wr(1'b0, 12'h7A0, 32'd0);
        wr(1'b0, 12'h7A1, 32'h0000_0800);
        rd(1'b0, 12'h7A1);
        dbg = 2'b01;
        wr(1'b0, 12'h7A0, 32'd1);
        wr(1'b0, 12'h7A1, 32'h0000_0000);
        dbg = 2'b00;
        wr(1'b0, 12'h7A0, 32'd0);
        wr(1'b0, 12'h7A1, 32'h0000_1800);   // action=1 as well
        rd(1'b0, 12'h7A1);
        wr(1'b0, 12'h7A0, 32'd1);
        wr(1'b0, 12'h7A1, 32'h0000_2800);   // odd trigger: chain stays 0, action 2 -> 0
        rd(1'b0, 12'h7A1);

        // Read and write of tselect in the same cycle, then re-read, bad write.
        ren = 1'b1; rtid = 1'b0; raddr = 12'h7A0;
        wr(1'b0, 12'h7A0, 32'd2);
        rd(1'b0, 12'h7A0);
        wr(1'b0, 12'h7A0, 32'd5);
        rd(1'b0, 12'h7A0);
        rd(1'b0, 12'h123);
        tick();

        // Thread 1 independence.
        wr(1'b1, 12'h7A0, 32'd3);
        wr(1'b1, 12'h7A1, 32'h0000_00C3);
        wr(1'b1, 12'h7A2, 32'hDEAD_BEEF);
        rd(1'b1, 12'h7A1);
        rd(1'b0, 12'h7A0);

        // Reset mid-operation: read and write in flight when reset hits.
        ren = 1'b1; rtid = 1'b1; raddr = 12'h7A2;
        wr(1'b1, 12'h7A2, 32'h5555_AAAA);
        rst_l = 1'b0;
        wr(1'b1, 12'h7A2, 32'h1111_2222);
        rd(1'b1, 12'h7A2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_l = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) dbg = 2'($urandom);
            hit = 8'd0;
            for (int e = 0; e < 8; e++) hit[e] = ($urandom_range(0, 15) == 0);
            wen   = ($urandom_range(0, 2) == 0);
            wtid  = 1'($urandom);
            waddr = addrs[$urandom_range(0, 7)];
            wdata = $urandom;
            if (waddr == 12'h7A0 && $urandom_range(0, 3) != 0) wdata = $urandom_range(0, 7);
            if (waddr == 12'h7A1 && $urandom_range(0, 1) == 0)
                wdata[15:12] = 4'($urandom_range(0, 2));
            ren   = ($urandom_range(0, 2) == 0);
            rtid  = 1'($urandom);
            raddr = addrs[$urandom_range(0, 7)];
            tick();
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
